// File: rtl/imm_gen_pipe.sv
// Decode-stage immediate generator: classifies the RV32 format, sign-extends the
// immediate to XLEN, precomputes pc + imm and buffers results in a 2-entry elastic FIFO.
module imm_gen_pipe #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_type,
    output logic            out_illegal,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_target
);

    localparam logic [2:0] TYPE_NONE = 3'd0;
    localparam logic [2:0] TYPE_I    = 3'd1;
    localparam logic [2:0] TYPE_S    = 3'd2;
    localparam logic [2:0] TYPE_B    = 3'd3;
    localparam logic [2:0] TYPE_U    = 3'd4;
    localparam logic [2:0] TYPE_J    = 3'd5;

    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_OP     = 7'b0110011;

    logic [6:0]      opcode;
    logic [31:0]     dec_imm32;
    logic [2:0]      dec_type;
    logic            dec_illegal;
    logic [XLEN-1:0] dec_imm;
    logic [XLEN-1:0] dec_target;

    logic [1:0]      count_q, count_d;
    logic            wr_ptr_q, wr_ptr_d;
    logic            rd_ptr_q, rd_ptr_d;
    logic [XLEN-1:0] imm_q     [2];
    logic [XLEN-1:0] imm_d     [2];
    logic [2:0]      type_q    [2];
    logic [2:0]      type_d    [2];
    logic            illegal_q [2];
    logic            illegal_d [2];
    logic [XLEN-1:0] pc_q      [2];
    logic [XLEN-1:0] pc_d      [2];
    logic [XLEN-1:0] target_q  [2];
    logic [XLEN-1:0] target_d  [2];

    logic            push;
    logic            pop;

    assign opcode = in_instr[6:0];

    // Immediates are first assembled as 32-bit two's-complement values, then widened.
    always_comb begin
        dec_imm32   = '0;
        dec_type    = TYPE_NONE;
        dec_illegal = 1'b0;
        if (opcode[1:0] != 2'b11) begin
            dec_illegal = 1'b1;
        end else begin
            case (opcode)
                OP_OPIMM, OP_LOAD, OP_JALR, OP_FENCE, OP_SYSTEM: begin
                    dec_type  = TYPE_I;
                    dec_imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
                end
                OP_STORE: begin
                    dec_type  = TYPE_S;
                    dec_imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
                end
                OP_BRANCH: begin
                    dec_type  = TYPE_B;
                    dec_imm32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                                 in_instr[30:25], in_instr[11:8], 1'b0};
                end
                OP_LUI, OP_AUIPC: begin
                    dec_type  = TYPE_U;
                    dec_imm32 = {in_instr[31:12], 12'b0};
                end
                OP_JAL: begin
                    dec_type  = TYPE_J;
                    dec_imm32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                                 in_instr[20], in_instr[30:21], 1'b0};
                end
                OP_OP: begin
                    dec_type = TYPE_NONE;
                end
                default: begin
                    dec_illegal = 1'b1;
                end
            endcase
        end
    end

    assign dec_imm    = XLEN'($signed(dec_imm32));
    assign dec_target = in_pc + dec_imm;

    // in_ready looks only at registered occupancy and reset, never at the consumer.
    assign in_ready  = rst_n && (count_q != 2'd2);
    assign out_valid = (count_q != 2'd0);
    assign push      = in_valid && in_ready && !flush;
    assign pop       = out_valid && out_ready && !flush;

    always_comb begin
        count_d   = count_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        imm_d     = imm_q;
        type_d    = type_q;
        illegal_d = illegal_q;
        pc_d      = pc_q;
        target_d  = target_q;
        if (flush) begin
            count_d  = 2'd0;
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
        end else begin
            if (push) begin
                for (int i = 0; i < 2; i++) begin
                    if (wr_ptr_q == 1'(i)) begin
                        imm_d[i]     = dec_imm;
                        type_d[i]    = dec_type;
                        illegal_d[i] = dec_illegal;
                        pc_d[i]      = in_pc;
                        target_d[i]  = dec_target;
                    end
                end
                wr_ptr_d = ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q  <= 2'd0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                imm_q[i]     <= '0;
                type_q[i]    <= TYPE_NONE;
                illegal_q[i] <= 1'b0;
                pc_q[i]      <= '0;
                target_q[i]  <= '0;
            end
        end else begin
            count_q   <= count_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            imm_q     <= imm_d;
            type_q    <= type_d;
            illegal_q <= illegal_d;
            pc_q      <= pc_d;
            target_q  <= target_d;
        end
    end

    assign out_imm     = imm_q[rd_ptr_q];
    assign out_type    = type_q[rd_ptr_q];
    assign out_illegal = illegal_q[rd_ptr_q];
    assign out_pc      = pc_q[rd_ptr_q];
    assign out_target  = target_q[rd_ptr_q];

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: XLEN=32 and XLEN=64 instances driven in lockstep and
// compared against a queue-based reference model plus fixed decode vectors.
module tb_imm_gen_pipe;

    typedef struct {
        logic [63:0] imm;
        logic [2:0]  typ;
        logic        ill;
        logic [63:0] pc;
        logic [63:0] tgt;
    } exp_t;

    typedef struct {
        logic [31:0] instr;
        logic [63:0] pc;
        logic [63:0] imm;
        logic [2:0]  typ;
        logic        ill;
        logic [63:0] tgt;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc32;
    logic [63:0] in_pc64;

    logic        in_ready32, out_valid32, out_illegal32;
    logic [2:0]  out_type32;
    logic [31:0] out_imm32, out_pc32, out_target32;
    logic        in_ready64, out_valid64, out_illegal64;
    logic [2:0]  out_type64;
    logic [63:0] out_imm64, out_pc64, out_target64;

    exp_t model_q[$];
    vec_t vecs[10];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready32), .in_instr(in_instr), .in_pc(in_pc32),
        .out_valid(out_valid32), .out_ready(out_ready), .out_imm(out_imm32),
        .out_type(out_type32), .out_illegal(out_illegal32), .out_pc(out_pc32),
        .out_target(out_target32)
    );

    imm_gen_pipe #(.XLEN(64)) dut64 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready64), .in_instr(in_instr), .in_pc(in_pc64),
        .out_valid(out_valid64), .out_ready(out_ready), .out_imm(out_imm64),
        .out_type(out_type64), .out_illegal(out_illegal64), .out_pc(out_pc64),
        .out_target(out_target64)
    );

    // Reference decode built from the instruction-set rules using signed arithmetic.
    function automatic exp_t refDecode(input logic [31:0] instr, input logic [63:0] pc);
        exp_t   e;
        longint s;
        longint v;
        e.typ = 3'd0;
        e.ill = 1'b0;
        v     = 0;
        s     = longint'($signed(instr));
        if (instr[1:0] != 2'b11) begin
            e.ill = 1'b1;
        end else begin
            case (instr[6:0])
                7'h13, 7'h03, 7'h67, 7'h0F, 7'h73: begin
                    e.typ = 3'd1;
                    v = s >>> 20;
                end
                7'h23: begin
                    e.typ = 3'd2;
                    v = (s >>> 25) * 32 + longint'(instr[11:7]);
                end
                7'h63: begin
                    e.typ = 3'd3;
                    v = longint'(instr[7]) * 2048 + longint'(instr[30:25]) * 32
                        + longint'(instr[11:8]) * 2;
                    if (instr[31]) v = v - 4096;
                end
                7'h37, 7'h17: begin
                    e.typ = 3'd4;
                    v = (s >>> 12) * 4096;
                end
                7'h6F: begin
                    e.typ = 3'd5;
                    v = longint'(instr[19:12]) * 4096 + longint'(instr[20]) * 2048
                        + longint'(instr[30:21]) * 2;
                    if (instr[31]) v = v - 1048576;
                end
                7'h33: begin
                    e.typ = 3'd0;
                end
                default: begin
                    e.ill = 1'b1;
                end
            endcase
        end
        e.imm = 64'(v);
        e.pc  = pc;
        e.tgt = pc + e.imm;
        return e;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkHead(input string tag, input exp_t e);
        check({tag, " imm32"},    64'(out_imm32),     64'(e.imm[31:0]));
        check({tag, " type32"},   64'(out_type32),    64'(e.typ));
        check({tag, " ill32"},    64'(out_illegal32), 64'(e.ill));
        check({tag, " pc32"},     64'(out_pc32),      64'(e.pc[31:0]));
        check({tag, " target32"}, 64'(out_target32),  64'(e.tgt[31:0]));
        check({tag, " imm64"},    out_imm64,          e.imm);
        check({tag, " type64"},   64'(out_type64),    64'(e.typ));
        check({tag, " ill64"},    64'(out_illegal64), 64'(e.ill));
        check({tag, " pc64"},     out_pc64,           e.pc);
        check({tag, " target64"}, out_target64,       e.tgt);
    endtask

    task automatic checkOutput();
        logic exp_rdy;
        logic exp_vld;
        exp_rdy = rst_n && (model_q.size() != 2);
        exp_vld = (model_q.size() != 0);
        check("in_ready32",  64'(in_ready32),  64'(exp_rdy));
        check("in_ready64",  64'(in_ready64),  64'(exp_rdy));
        check("out_valid32", 64'(out_valid32), 64'(exp_vld));
        check("out_valid64", 64'(out_valid64), 64'(exp_vld));
        if (exp_vld) checkHead("model head", model_q[0]);
    endtask

    // Drives one cycle of inputs, advances the model across the edge, then checks.
    task automatic applyStimulus(input logic v, input logic [31:0] instr, input logic [63:0] pc,
                                 input logic ordy, input logic fl);
        logic do_push;
        logic do_pop;
        in_valid  = v;
        in_instr  = instr;
        in_pc64   = pc;
        in_pc32   = pc[31:0];
        out_ready = ordy;
        flush     = fl;
        do_push   = rst_n && v && (model_q.size() != 2) && !fl;
        do_pop    = rst_n && (model_q.size() != 0) && ordy && !fl;
        @(posedge clk);
        if (!rst_n || fl) begin
            model_q.delete();
        end else begin
            if (do_pop) void'(model_q.pop_front());
            if (do_push) model_q.push_back(refDecode(instr, pc));
        end
        #1;
        checkOutput();
    endtask

    task automatic checkAllZero(input string tag);
        check({tag, " imm32"},    64'(out_imm32),     64'h0);
        check({tag, " type32"},   64'(out_type32),    64'h0);
        check({tag, " ill32"},    64'(out_illegal32), 64'h0);
        check({tag, " pc32"},     64'(out_pc32),      64'h0);
        check({tag, " target32"}, 64'(out_target32),  64'h0);
        check({tag, " imm64"},    out_imm64,          64'h0);
        check({tag, " pc64"},     out_pc64,           64'h0);
        check({tag, " target64"}, out_target64,       64'h0);
    endtask

    function automatic logic [31:0] randInstr();
        logic [6:0]  ops [11];
        logic [31:0] w;
        ops = '{7'h13, 7'h03, 7'h67, 7'h0F, 7'h73, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33};
        w = $urandom;
        if ($urandom_range(0, 7) != 0) w[6:0] = ops[$urandom_range(0, 10)];
        return w;
    endfunction

    initial begin
        exp_t e;
        rst_n = 1'b0;
        vecs[0] = '{32'hFFF00093, 64'h100,  64'hFFFF_FFFF_FFFF_FFFF, 3'd1, 1'b0, 64'hFF};
        vecs[1] = '{32'hFFC00067, 64'h0,    64'hFFFF_FFFF_FFFF_FFFC, 3'd1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFC};
        vecs[2] = '{32'hFE000EE3, 64'h200,  64'hFFFF_FFFF_FFFF_FFFC, 3'd3, 1'b0, 64'h1FC};
        vecs[3] = '{32'h0010006F, 64'h1000, 64'h800,                 3'd5, 1'b0, 64'h1800};
        vecs[4] = '{32'h800000B7, 64'h0,    64'hFFFF_FFFF_8000_0000, 3'd4, 1'b0, 64'hFFFF_FFFF_8000_0000};
        vecs[5] = '{32'h00000000, 64'h300,  64'h0,                   3'd0, 1'b1, 64'h300};
        vecs[6] = '{32'hFE20AC23, 64'h40,   64'hFFFF_FFFF_FFFF_FFF8, 3'd2, 1'b0, 64'h38};
        vecs[7] = '{32'h00001017, 64'h10,   64'h1000,                3'd4, 1'b0, 64'h1010};
        vecs[8] = '{32'h002081B3, 64'h20,   64'h0,                   3'd0, 1'b0, 64'h20};
        vecs[9] = '{32'h0000007F, 64'h50,   64'h0,                   3'd0, 1'b1, 64'h50};

        applyStimulus(1'b0, 32'h0, 64'h0, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'hFFF00093, 64'h100, 1'b1, 1'b0);
        checkAllZero("reset state");
        rst_n = 1'b1;

        $display("[TB] decode vectors");
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, vecs[i].instr, vecs[i].pc, 1'b1, 1'b0);
            e = '{vecs[i].imm, vecs[i].typ, vecs[i].ill, vecs[i].pc, vecs[i].tgt};
            check($sformatf("vec%0d valid", i), 64'(out_valid32 & out_valid64), 64'h1);
            checkHead($sformatf("vec%0d", i), e);
        end
        applyStimulus(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);

        $display("[TB] back-pressure");
        applyStimulus(1'b1, 32'h00100093, 64'h400, 1'b0, 1'b0);
        check("bp A head", 64'(out_pc32), 64'h400);
        applyStimulus(1'b1, 32'h0010006F, 64'h404, 1'b0, 1'b0);
        check("bp full in_ready", 64'(in_ready32), 64'h0);
        check("bp A held", 64'(out_pc32), 64'h400);
        applyStimulus(1'b1, 32'hFE000EE3, 64'h408, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'hFE000EE3, 64'h408, 1'b0, 1'b0);
        check("bp A stall imm", out_imm64, 64'h1);
        check("bp A stall pc", out_pc64, 64'h400);
        applyStimulus(1'b1, 32'hFE000EE3, 64'h408, 1'b1, 1'b0);
        check("bp B out", 64'(out_pc32), 64'h404);
        check("bp in_ready rise", 64'(in_ready32), 64'h1);
        applyStimulus(1'b1, 32'hFE000EE3, 64'h408, 1'b1, 1'b0);
        check("bp C out", 64'(out_pc32), 64'h408);
        check("bp C valid", 64'(out_valid32), 64'h1);
        applyStimulus(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
        check("bp drained", 64'(out_valid64), 64'h0);

        $display("[TB] flush");
        applyStimulus(1'b1, 32'h00500093, 64'h600, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h00600093, 64'h604, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h00700093, 64'h500, 1'b1, 1'b1);
        check("flush out_valid", 64'(out_valid32), 64'h0);
        check("flush in_ready", 64'(in_ready64), 64'h1);
        applyStimulus(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
        applyStimulus(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);

        $display("[TB] reset mid-operation");
        applyStimulus(1'b1, 32'h00500093, 64'h700, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h0010006F, 64'h704, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        check("rst in_ready32", 64'(in_ready32), 64'h0);
        check("rst in_ready64", 64'(in_ready64), 64'h0);
        applyStimulus(1'b1, 32'h00500093, 64'h708, 1'b1, 1'b0);
        checkAllZero("post reset");
        rst_n = 1'b1;
        #1;
        check("post reset valid", 64'(out_valid32), 64'h0);
        applyStimulus(1'b1, 32'h0010006F, 64'h2000, 1'b0, 1'b0);
        check("post reset push pc", out_pc64, 64'h2000);
        check("post reset push tgt", out_target64, 64'h2800);
        applyStimulus(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);

        $display("[TB] random traffic");
        for (int n = 0; n < 400; n++) begin
            applyStimulus($urandom_range(0, 3) != 0, randInstr(), {$urandom, $urandom},
                          $urandom_range(0, 2) != 0, $urandom_range(0, 19) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
